interp_inverse_search: RTL and testbench
========================================

# interp_inverse_search

- Inverse of the 8-segment piecewise linear interpolator: given a target output value and the same eight segment weights, finds the 8-bit input code whose interpolated output is closest to the target.
- Search is an exhaustive scan of all input codes, one candidate per clock, with early exit on an exact match.
- Sits beside the interpolator in the 2D interpolation path and supplies input codes for a requested output level, e.g. for calibration and table inversion.

## Interface
- BW_X, 8, input code width; the block is defined for 8 only (8 segments).
- BW_WEIGHT, 10, weight, target and output width.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  request a search; sampled only in IDLE.
- i_target  in  BW_WEIGHT  requested output value, unsigned.
- i_weight0..i_weight7  in  BW_WEIGHT each  segment weights, unsigned.
- o_busy  out  1  high while a search is running.
- o_done  out  1  one-cycle pulse when a search completes.
- o_x  out  BW_X  best input code of the last completed search.
- o_y  out  BW_WEIGHT  model output at o_x.
- o_err  out  BW_WEIGHT  |o_y − target|.

## Operation
- **Reset values:** all outputs are 0; state is IDLE. A reset during SCAN aborts the search: no o_done pulse, results cleared to 0.
- **FSM states:** IDLE and SCAN.
  - IDLE → SCAN on i_start.
  - At that edge: capture i_target and all eight weights into registers, set cnt=0, set best_err=2^BW_WEIGHT (11-bit register, so candidate 0 is always accepted).
  - Inputs may change freely after the capture edge.
- **Forward model f(x)**, combinational on the captured weights:
  - k = index of the highest set bit of x.
  - Weight pair (wA,wB):
    - k=7: (w0,w1)
    - k=6: (w1,w2)
    - k=5: (w2,w3)
    - k=4: (w3,w4)
    - k=3: (w4,w5)
    - k=2: (w5,w6)
    - k≤1 or x=0: (w6,w7)
  - t1 (7 bits) = x[6:0], with bit k cleared when 1≤k≤6.
  - t2 (7 bits):
    - 1≤k≤6: zero-extended bitwise NOT of t1[k−1:0], plus 1.
    - otherwise: t2 = 1.
  - Products are 17 bits wide and the sum is 18 bits wide.
  - f(x) = (t1·wA + t2·wB) mod 2^BW_WEIGHT, i.e. the low bits are kept with silent wrap.
- **SCAN, each cycle:**
  - Evaluate x=cnt and compute err=|f(cnt) − target| (unsigned).
  - If err < best_err (strictly less), update best_x, best_y and best_err. On ties the lowest x wins.
- **Leaving SCAN:** when err==0 or cnt==255, go to IDLE.
  - At that edge, load o_x/o_y/o_err from the best values, including the current candidate if it improved.
  - Pulse o_done for one cycle.
  - Otherwise cnt increments.
- **Starts:** i_start is ignored while in SCAN. A start in the o_done cycle (state IDLE) is accepted.
- **Outputs:** o_x/o_y/o_err hold their values until the next completion or reset.

## Timing
- Let E0 be the edge that samples i_start, and N the number of candidates evaluated: the matching x+1 on an exact match, else 256.
- o_busy is high from after E0 until edge E0+N.
- o_done is high for exactly the cycle after edge E0+N. Results are valid in that same cycle.
- Latency bounds:
  - Minimum 1 clock (exact match at x=0).
  - Maximum 256 clocks.
- A back-to-back start in the o_done cycle begins a new scan with o_busy high in the next cycle.
- There are no combinational paths from inputs to outputs.

## Test plan
- **Exact match at x=0:** all weights 0, target 0, start → o_done 1 clock after E0; o_x=0, o_y=0, o_err=0.
- **No match, full scan:** all weights 0, target 5 → o_done 256 clocks after E0; o_x=0 (tie rule), o_y=0, o_err=5.
- **Mid-table exact match:** all weights 1, target 100 → f(x)=x−127 for x≥128, so exact at x=227; o_done 228 clocks after E0; o_x=227, o_y=100, o_err=0.
- **Wrap/truncation:** w0=w1=1023, others 0, target 896 → f(255)=128·1023 mod 1024=896; o_done 256 clocks after E0; o_x=255, o_y=896, o_err=0.
- **Max error, unreachable target:** all weights 1, target 1023 → o_x=255, o_y=128, o_err=895, done at 256 clocks.
- **Abort and robustness:**
  - Run the 5-target scan and assert rst for one cycle at clock 100 → o_busy=0, all outputs 0, no o_done.
  - Restart, then pulse i_start and change weights at clock 50 → start is ignored, and the result is unchanged from the captured-weight expectation.

Source files
------------

// File: rtl/interp_inverse_search.sv
// Inverse search for the 8-segment piecewise linear interpolator: scans input codes 0..255,
// one per clock, and reports the code whose interpolated output is closest to the target.
module interp_inverse_search #(
  parameter int unsigned BW_X      = 8,
  parameter int unsigned BW_WEIGHT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [BW_WEIGHT-1:0] i_target,
  input  logic [BW_WEIGHT-1:0] i_weight0,
  input  logic [BW_WEIGHT-1:0] i_weight1,
  input  logic [BW_WEIGHT-1:0] i_weight2,
  input  logic [BW_WEIGHT-1:0] i_weight3,
  input  logic [BW_WEIGHT-1:0] i_weight4,
  input  logic [BW_WEIGHT-1:0] i_weight5,
  input  logic [BW_WEIGHT-1:0] i_weight6,
  input  logic [BW_WEIGHT-1:0] i_weight7,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [BW_X-1:0]      o_x,
  output logic [BW_WEIGHT-1:0] o_y,
  output logic [BW_WEIGHT-1:0] o_err
);

  localparam int unsigned BW_T = BW_X - 1;
  localparam int unsigned BW_P = BW_T + BW_WEIGHT;

  typedef enum logic {StIdle, StScan} state_e;

  state_e               r_state, w_state_d;
  logic [BW_WEIGHT-1:0] r_w [8];
  logic [BW_WEIGHT-1:0] r_target;
  logic [BW_X-1:0]      r_cnt, r_best_x, r_x;
  logic [BW_WEIGHT-1:0] r_best_y, r_y, r_err;
  logic [BW_WEIGHT:0]   r_best_err;
  logic                 r_done;

  logic [2:0]           w_k, w_idx;
  logic [BW_T-1:0]      w_mask, w_t1, w_t2;
  logic [BW_WEIGHT-1:0] w_wa, w_wb, w_y, w_err;
  logic [BW_P-1:0]      w_p1, w_p2;
  logic [BW_P:0]        w_sum;
  logic                 w_better, w_capture, w_finish;

  // Forward model on the captured weights, evaluated at x = r_cnt
  always_comb begin
    w_k = '0;
    for (int i = 1; i < int'(BW_X); i++) begin
      if (r_cnt[i]) w_k = 3'(i);
    end
    w_idx  = (w_k == 3'd0) ? 3'd6 : 3'd7 - w_k;
    w_wa   = r_w[w_idx];
    w_wb   = r_w[w_idx + 3'd1];
    w_mask = ~({BW_T{1'b1}} << w_k);
    if (w_k == 3'd0 || w_k == 3'd7) begin
      w_t1 = r_cnt[BW_T-1:0];
      w_t2 = BW_T'(1);
    end else begin
      w_t1 = r_cnt[BW_T-1:0] & w_mask;
      w_t2 = (~w_t1 & w_mask) + BW_T'(1);
    end
    w_p1     = {{BW_WEIGHT{1'b0}}, w_t1} * {{BW_T{1'b0}}, w_wa};
    w_p2     = {{BW_WEIGHT{1'b0}}, w_t2} * {{BW_T{1'b0}}, w_wb};
    w_sum    = {1'b0, w_p1} + {1'b0, w_p2};
    w_y      = w_sum[BW_WEIGHT-1:0];
    w_err    = (w_y >= r_target) ? w_y - r_target : r_target - w_y;
    w_better = {1'b0, w_err} < r_best_err;
  end

  always_comb begin
    w_state_d = r_state;
    w_capture = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_capture = 1'b1;
          w_state_d = StScan;
        end
      end
      StScan: begin
        if (w_err == '0 || r_cnt == {BW_X{1'b1}}) begin
          w_finish  = 1'b1;
          w_state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_done     <= 1'b0;
      r_target   <= '0;
      r_cnt      <= '0;
      r_best_x   <= '0;
      r_best_y   <= '0;
      r_best_err <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_err      <= '0;
      for (int i = 0; i < 8; i++) r_w[i] <= '0;
    end else begin
      r_state <= w_state_d;
      r_done  <= w_finish;
      if (w_capture) begin
        r_target   <= i_target;
        r_w[0]     <= i_weight0;
        r_w[1]     <= i_weight1;
        r_w[2]     <= i_weight2;
        r_w[3]     <= i_weight3;
        r_w[4]     <= i_weight4;
        r_w[5]     <= i_weight5;
        r_w[6]     <= i_weight6;
        r_w[7]     <= i_weight7;
        r_cnt      <= '0;
        // One above any reachable error so candidate 0 always wins
        r_best_err <= {1'b1, {BW_WEIGHT{1'b0}}};
      end
      if (r_state == StScan) begin
        if (w_better) begin
          r_best_x   <= r_cnt;
          r_best_y   <= w_y;
          r_best_err <= {1'b0, w_err};
        end
        if (w_finish) begin
          r_x   <= w_better ? r_cnt : r_best_x;
          r_y   <= w_better ? w_y : r_best_y;
          r_err <= w_better ? w_err : r_best_err[BW_WEIGHT-1:0];
        end else begin
          r_cnt <= r_cnt + BW_X'(1);
        end
      end
    end
  end

  assign o_busy = (r_state == StScan);
  assign o_done = r_done;
  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_err  = r_err;

endmodule

// File: tb/tb_interp_inverse_search.sv
// Randomised scoreboard bench for interp_inverse_search against a behavioural search model.
module tb_interp_inverse_search;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [9:0] i_target = '0;
  logic [9:0] wv [8];
  logic       o_busy, o_done;
  logic [7:0] o_x;
  logic [9:0] o_y, o_err;

  interp_inverse_search #(.BW_X(8), .BW_WEIGHT(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_target (i_target),
    .i_weight0(wv[0]),
    .i_weight1(wv[1]),
    .i_weight2(wv[2]),
    .i_weight3(wv[3]),
    .i_weight4(wv[4]),
    .i_weight5(wv[5]),
    .i_weight6(wv[6]),
    .i_weight7(wv[7]),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_x      (o_x),
    .o_y      (o_y),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int err; int lat; int base;} exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   ncnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Segment k = floor(log2 x); segment spans [2^k, 2^(k+1)) and blends its two weights
  function automatic int fmodel(input int x, input int w[8]);
    int k, t1, t2, wa, wb;
    k = 0;
    for (int i = 0; i < 8; i++) if (x >= (1 << i)) k = i;
    if (k == 7) begin
      t1 = x - 128; t2 = 1; wa = w[0]; wb = w[1];
    end else if (k >= 1) begin
      t1 = x - (1 << k); t2 = (1 << k) - t1; wa = w[7-k]; wb = w[8-k];
    end else begin
      t1 = x; t2 = 1; wa = w[6]; wb = w[7];
    end
    return (t1 * wa + t2 * wb) % 1024;
  endfunction

  function automatic exp_t ref_search(input int tgt, input int w[8]);
    exp_t r;
    int   best, y, e;
    best  = 1 << 30;
    r.x   = 0; r.y = 0; r.err = 0; r.lat = 256; r.base = 0;
    for (int x = 0; x < 256; x++) begin
      y = fmodel(x, w);
      e = (y > tgt) ? y - tgt : tgt - y;
      if (e < best) begin
        best = e; r.x = x; r.y = y; r.err = e;
      end
      if (e == 0) begin
        r.lat = x + 1;
        break;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    i_target = 10'($urandom);
    for (int i = 0; i < 8; i++) wv[i] = 10'($urandom);
  endtask

  task automatic issue(input int tgt, input int w[8], input bit push);
    exp_t e;
    i_target = 10'(tgt);
    for (int i = 0; i < 8; i++) wv[i] = 10'(w[i]);
    i_start = 1'b1;
    if (push) begin
      e      = ref_search(tgt, w);
      e.base = ncnt + 2;
      q.push_back(e);
    end
    tick();
    i_start = 1'b0;
    scramble();
  endtask

  task automatic wait_done();
    int b = 0;
    while (!o_done && b < 300) begin
      tick();
      b++;
    end
    chk("done_within_budget", int'(o_done), 1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_x"}, int'(o_x), 0);
    chk({tag, "_y"}, int'(o_y), 0);
    chk({tag, "_err"}, int'(o_err), 0);
  endtask

  always @(negedge clk) begin
    ncnt++;
    if (o_done) begin
      chk("done_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("o_x", int'(o_x), mon_e.x);
        chk("o_y", int'(o_y), mon_e.y);
        chk("o_err", int'(o_err), mon_e.err);
        chk("latency", ncnt - mon_e.base, mon_e.lat);
      end
    end
  end

  initial begin
    int z[8], o[8], wr[8];
    int tgt, gap;
    for (int i = 0; i < 8; i++) begin
      z[i] = 0; o[i] = 1; wv[i] = '0;
    end

    repeat (3) tick();
    rst = 1'b0;
    chk_cleared("reset");

    issue(0, z, 1'b1);     wait_done(); tick();
    issue(5, z, 1'b1);     wait_done(); tick();
    issue(100, o, 1'b1);   wait_done(); tick();
    wr = '{1023, 1023, 0, 0, 0, 0, 0, 0};
    issue(896, wr, 1'b1);  wait_done(); tick();
    issue(1023, o, 1'b1);  wait_done();
    // Start issued in the done cycle must be accepted
    issue(100, o, 1'b1);
    chk("b2b_busy", int'(o_busy), 1);
    wait_done(); tick();

    // Abort mid-scan: results cleared, no done pulse may follow
    issue(5, z, 1'b0);
    repeat (98) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cleared("abort");
    repeat (300) tick();

    // A start pulse with new inputs during the scan must be ignored
    issue(100, o, 1'b1);
    repeat (48) tick();
    i_start  = 1'b1;
    i_target = '0;
    for (int i = 0; i < 8; i++) wv[i] = '0;
    tick();
    i_start = 1'b0;
    chk("busy_after_ignored_start", int'(o_busy), 1);
    wait_done(); tick();

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 8; i++) wr[i] = int'($urandom_range(1023));
      if ($urandom_range(1) == 1) tgt = fmodel(int'($urandom_range(255)), wr);
      else tgt = int'($urandom_range(1023));
      issue(tgt, wr, 1'b1);
      wait_done();
      gap = int'($urandom_range(2));
      repeat (gap) tick();
    end

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
